// File: rtl/dram_cmd_scheduler_if.sv
// Request/response handshake plus DRAM pin bundle between the wrapper logic and the scheduler.
// The master side is the wrapper (and, in simulation, the DRAM model); the slave side is the scheduler.
interface dram_cmd_scheduler_if;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned PIN_A_W = 11;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [ADDR_W-1:0]    req_addr;
  logic [DATA_W-1:0]    req_wdata;
  logic [STRB_W-1:0]    req_wstrb;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [DATA_W-1:0]    rsp_rdata;
  logic                 DRAM_CSn;
  logic [STRB_W-1:0]    DRAM_WEn;
  logic                 DRAM_RASn;
  logic                 DRAM_CASn;
  logic [PIN_A_W-1:0]   DRAM_A;
  logic [DATA_W-1:0]    DRAM_D;
  logic                 DRAM_valid;
  logic [DATA_W-1:0]    DRAM_Q;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready, DRAM_valid, DRAM_Q,
    input  req_ready, rsp_valid, rsp_rdata,
    input  DRAM_CSn, DRAM_WEn, DRAM_RASn, DRAM_CASn, DRAM_A, DRAM_D
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready, DRAM_valid, DRAM_Q,
    output req_ready, rsp_valid, rsp_rdata,
    output DRAM_CSn, DRAM_WEn, DRAM_RASn, DRAM_CASn, DRAM_A, DRAM_D
  );
endinterface

// File: rtl/dram_cmd_scheduler.sv
// Single-outstanding DRAM command sequencer with an open-row policy.
// Each command is a one-cycle registered pin pattern; PRE/ACT/WR gaps are timed by a shared down-counter.
module dram_cmd_scheduler #(
  parameter int unsigned T_RP  = 5,
  parameter int unsigned T_RCD = 5,
  parameter int unsigned T_WR  = 5
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  dram_cmd_scheduler_if.slave   bus
);
  localparam int unsigned ROW_W  = 11;
  localparam int unsigned COL_W  = 10;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PRE    = 3'd1;
  localparam logic [2:0] ST_ACT    = 3'd2;
  localparam logic [2:0] ST_RDWAIT = 3'd3;
  localparam logic [2:0] ST_WRWAIT = 3'd4;
  localparam logic [2:0] ST_RESP   = 3'd5;

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_PRE = 3'd1;
  localparam logic [2:0] CMD_ACT = 3'd2;
  localparam logic [2:0] CMD_RD  = 3'd3;
  localparam logic [2:0] CMD_WR  = 3'd4;

  logic [2:0]        r_state, w_next_state;
  logic [CNT_W-1:0]  r_cnt, w_cnt;
  logic              r_row_open, w_row_open;
  logic [ROW_W-1:0]  r_open_row, w_open_row;
  logic [ROW_W-1:0]  r_row, w_row;
  logic [COL_W-1:0]  r_col, w_col;
  logic              r_write, w_write;
  logic [DATA_W-1:0] r_wdata, w_wdata;
  logic [STRB_W-1:0] r_wstrb, w_wstrb;
  logic              r_req_ready, w_req_ready;
  logic              r_rsp_valid, w_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata;
  logic              r_rasn, w_rasn;
  logic              r_casn, w_casn;
  logic              r_csn;
  logic [STRB_W-1:0] r_wen, w_wen;
  logic [ROW_W-1:0]  r_a, w_a;
  logic [DATA_W-1:0] r_d, w_d;
  logic              w_accept, w_do_act, w_do_cas;
  logic [2:0]        w_cmd;
  logic              w_unused_addr;

  assign w_unused_addr = ^{bus.req_addr[31:23], bus.req_addr[1:0]};

  // First command is issued from the request as it arrives; later ones use the latched copy.
  assign w_accept = (r_state == ST_IDLE) && r_req_ready && bus.req_valid;
  assign w_row    = w_accept ? bus.req_addr[22:12] : r_row;
  assign w_col    = w_accept ? bus.req_addr[11:2]  : r_col;
  assign w_write  = w_accept ? bus.req_write       : r_write;
  assign w_wdata  = w_accept ? bus.req_wdata       : r_wdata;
  assign w_wstrb  = w_accept ? bus.req_wstrb       : r_wstrb;

  always_comb begin
    w_next_state = r_state;
    w_cnt        = (r_cnt != '0) ? r_cnt - CNT_W'(1) : r_cnt;
    w_row_open   = r_row_open;
    w_open_row   = r_open_row;
    w_rsp_valid  = r_rsp_valid;
    w_rsp_rdata  = r_rsp_rdata;
    w_cmd        = CMD_NOP;
    w_do_act     = 1'b0;
    w_do_cas     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (r_row_open && (w_row == r_open_row)) begin
            w_do_cas = 1'b1;
          end else if (r_row_open) begin
            w_cmd        = CMD_PRE;
            w_row_open   = 1'b0;
            w_cnt        = CNT_W'(T_RP - 1);
            w_next_state = ST_PRE;
          end else begin
            w_do_act = 1'b1;
          end
        end
      end
      ST_PRE:    if (r_cnt == '0) w_do_act = 1'b1;
      ST_ACT:    if (r_cnt == '0) w_do_cas = 1'b1;
      ST_RDWAIT: begin
        if (bus.DRAM_valid) begin
          w_rsp_rdata  = bus.DRAM_Q;
          w_rsp_valid  = 1'b1;
          w_next_state = ST_RESP;
        end
      end
      ST_WRWAIT: begin
        if (r_cnt == '0) begin
          w_rsp_rdata  = '0;
          w_rsp_valid  = 1'b1;
          w_next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          w_rsp_valid  = 1'b0;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase

    if (w_do_act) begin
      w_cmd        = CMD_ACT;
      w_row_open   = 1'b1;
      w_open_row   = w_row;
      w_cnt        = CNT_W'(T_RCD - 1);
      w_next_state = ST_ACT;
    end
    if (w_do_cas) begin
      w_cmd        = w_write ? CMD_WR : CMD_RD;
      w_next_state = w_write ? ST_WRWAIT : ST_RDWAIT;
      if (w_write) w_cnt = CNT_W'(T_WR - 1);
    end

    w_req_ready = (w_next_state == ST_IDLE);

    // Pin encoding; NOP parks address/data at zero.
    w_rasn = 1'b1;
    w_casn = 1'b1;
    w_wen  = '1;
    w_a    = '0;
    w_d    = '0;
    case (w_cmd)
      CMD_PRE: begin w_rasn = 1'b0; w_wen = '0; w_a = r_open_row; end
      CMD_ACT: begin w_rasn = 1'b0; w_a = w_row; end
      CMD_RD:  begin w_casn = 1'b0; w_a = ROW_W'(w_col); end
      CMD_WR:  begin w_casn = 1'b0; w_wen = ~w_wstrb; w_a = ROW_W'(w_col); w_d = w_wdata; end
      default: ;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_row_open  <= 1'b0;
      r_open_row  <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_csn       <= 1'b1;
      r_rasn      <= 1'b1;
      r_casn      <= 1'b1;
      r_wen       <= '1;
      r_a         <= '0;
      r_d         <= '0;
    end else begin
      r_state     <= w_next_state;
      r_cnt       <= w_cnt;
      r_row_open  <= w_row_open;
      r_open_row  <= w_open_row;
      r_row       <= w_row;
      r_col       <= w_col;
      r_write     <= w_write;
      r_wdata     <= w_wdata;
      r_wstrb     <= w_wstrb;
      r_req_ready <= w_req_ready;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_rdata <= w_rsp_rdata;
      r_csn       <= 1'b0;
      r_rasn      <= w_rasn;
      r_casn      <= w_casn;
      r_wen       <= w_wen;
      r_a         <= w_a;
      r_d         <= w_d;
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.DRAM_CSn  = r_csn;
  assign bus.DRAM_RASn = r_rasn;
  assign bus.DRAM_CASn = r_casn;
  assign bus.DRAM_WEn  = r_wen;
  assign bus.DRAM_A    = r_a;
  assign bus.DRAM_D    = r_d;
endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Directed bench for dram_cmd_scheduler: command timing, row hit/miss, response hold, reset abort.
module tb_dram_cmd_scheduler;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  dram_cmd_scheduler_if bus ();

  dram_cmd_scheduler #(.T_RP(5), .T_RCD(5), .T_WR(5)) dut (
    .ACLK    (clk),
    .ARESETn (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // {CSn,RASn,CASn,WEn[3:0],A[10:0]}
  function automatic logic [31:0] pins_now();
    return 32'({bus.DRAM_CSn, bus.DRAM_RASn, bus.DRAM_CASn, bus.DRAM_WEn, bus.DRAM_A});
  endfunction

  function automatic logic [31:0] pins(input logic csn, input logic rasn, input logic casn,
                                       input logic [3:0] wen, input logic [10:0] a);
    return 32'({csn, rasn, casn, wen, a});
  endfunction

  task automatic chk_nop(input string tag);
    chk(tag, pins_now() >> 11, 32'h3F);
  endtask

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (bus.req_ready !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk(tag, 32'(bus.req_ready), 32'd1);
  endtask

  // Presents a request for one cycle; returns in the cycle after acceptance.
  task automatic send_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_wstrb = wstrb;
    tick();
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wstrb = '0;
  endtask

  task automatic pulse_q(input logic [31:0] q);
    bus.DRAM_valid = 1'b1;
    bus.DRAM_Q     = q;
    tick();
    bus.DRAM_valid = 1'b0;
    bus.DRAM_Q     = '0;
  endtask

  task automatic handshake();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("rsp_drop", 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_wstrb  = '0;
    bus.rsp_ready  = 1'b0;
    bus.DRAM_valid = 1'b0;
    bus.DRAM_Q     = '0;
    tick();
    tick();

    // Reset values
    chk("rst_pins", pins_now(), pins(1'b1, 1'b1, 1'b1, 4'hF, 11'h000));
    chk("rst_d", bus.DRAM_D, 32'h0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    rst_n = 1'b1;
    wait_ready("t1_ready");
    chk_nop("t1_idle_nop");

    // Test 1: cold read, ACT then RD after tRCD
    send_req(1'b0, 32'h0000_1004, 32'h0, 4'h0);
    chk("t1_act", pins_now(), pins(1'b0, 1'b0, 1'b1, 4'hF, 11'h001));
    chk("t1_busy", 32'(bus.req_ready), 32'd0);
    for (int i = 0; i < 4; i++) tick();
    chk_nop("t1_gap_nop");
    tick();
    chk("t1_rd", pins_now(), pins(1'b0, 1'b1, 1'b0, 4'hF, 11'h001));
    tick();
    chk("t1_no_rsp_yet", 32'(bus.rsp_valid), 32'd0);
    pulse_q(32'hDEAD_BEEF);
    chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("t1_rsp_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
    handshake();
    chk("t1_ready_after", 32'(bus.req_ready), 32'd1);

    // Test 2: row hit read, RD immediately
    send_req(1'b0, 32'h0000_1008, 32'h0, 4'h0);
    chk("t2_rd_hit", pins_now(), pins(1'b0, 1'b1, 1'b0, 4'hF, 11'h002));
    pulse_q(32'hCAFE_F00D);
    chk("t2_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("t2_rsp_rdata", bus.rsp_rdata, 32'hCAFE_F00D);

    // Test 4: response held without rsp_ready; stray DRAM_valid ignored
    for (int i = 0; i < 10; i++) begin
      chk("t4_hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("t4_hold_rdata", bus.rsp_rdata, 32'hCAFE_F00D);
      chk("t4_hold_ready", 32'(bus.req_ready), 32'd0);
      chk_nop("t4_hold_nop");
      if (i == 4) pulse_q(32'h5555_5555);
      else tick();
    end
    handshake();
    wait_ready("t3_ready");

    // Test 3: row miss write, PRE/ACT/WR then tWR
    send_req(1'b1, 32'h0000_2000, 32'h1234_5678, 4'b0011);
    chk("t3_pre", pins_now(), pins(1'b0, 1'b0, 1'b1, 4'h0, 11'h001));
    for (int i = 0; i < 5; i++) tick();
    chk("t3_act", pins_now(), pins(1'b0, 1'b0, 1'b1, 4'hF, 11'h002));
    for (int i = 0; i < 5; i++) tick();
    chk("t3_wr", pins_now(), pins(1'b0, 1'b1, 1'b0, 4'b1100, 11'h000));
    chk("t3_wr_d", bus.DRAM_D, 32'h1234_5678);
    for (int i = 0; i < 4; i++) tick();
    chk("t3_rsp_early", 32'(bus.rsp_valid), 32'd0);
    tick();
    chk("t3_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("t3_rsp_rdata", bus.rsp_rdata, 32'h0);
    handshake();
    wait_ready("t6_ready");

    // Test 6: DRAM_valid while idle
    pulse_q(32'hFFFF_0000);
    chk("t6_no_rsp", 32'(bus.rsp_valid), 32'd0);
    chk_nop("t6_nop");
    tick();
    chk("t6_still_idle", 32'(bus.req_ready), 32'd1);

    // Zero-strobe write on open row still issues WR with all byte enables off
    send_req(1'b1, 32'h0000_2004, 32'hA5A5_A5A5, 4'b0000);
    chk("t7_wr_nostrb", pins_now(), pins(1'b0, 1'b1, 1'b0, 4'hF, 11'h001));
    for (int i = 0; i < 5; i++) tick();
    chk("t7_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    handshake();
    wait_ready("t5_ready");

    // Test 5: reset during RDWAIT, next request reopens the row
    send_req(1'b0, 32'h0000_2008, 32'h0, 4'h0);
    chk("t5_rd_hit", pins_now(), pins(1'b0, 1'b1, 1'b0, 4'hF, 11'h002));
    tick();
    rst_n = 1'b0;
    tick();
    chk("t5_rst_pins", pins_now(), pins(1'b1, 1'b1, 1'b1, 4'hF, 11'h000));
    chk("t5_rst_rsp", 32'(bus.rsp_valid), 32'd0);
    chk("t5_rst_ready", 32'(bus.req_ready), 32'd0);
    rst_n = 1'b1;
    wait_ready("t5_ready2");
    send_req(1'b0, 32'h0000_200C, 32'h0, 4'h0);
    chk("t5_act_again", pins_now(), pins(1'b0, 1'b0, 1'b1, 4'hF, 11'h002));
    for (int i = 0; i < 5; i++) tick();
    chk("t5_rd", pins_now(), pins(1'b0, 1'b1, 1'b0, 4'hF, 11'h003));
    pulse_q(32'h0BAD_F00D);
    chk("t5_rsp_rdata", bus.rsp_rdata, 32'h0BAD_F00D);
    handshake();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
